// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, opcodes and the WB control bundle.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int REG_ZERO = 0;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB stage register with flush-over-stall priority.
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  wb_ctrl_t          i_ctrl,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [REG_AW-1:0] i_rd,
  output logic              o_valid,
  output wb_ctrl_t          o_ctrl,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic [REG_AW-1:0] o_rd
);
  logic              r_valid;
  wb_ctrl_t          r_ctrl;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_mem_rdata;
  logic [REG_AW-1:0] r_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_alu_result <= '0;
      r_mem_rdata  <= '0;
      r_rd         <= '0;
    end else if (!i_stall) begin
      r_valid      <= i_valid;
      r_ctrl       <= '{memtoreg: i_ctrl.memtoreg & i_valid, regwrite: i_ctrl.regwrite & i_valid};
      r_alu_result <= i_alu_result;
      r_mem_rdata  <= i_mem_rdata;
      r_rd         <= i_rd;
    end
  end
  assign o_valid      = r_valid;
  assign o_ctrl       = r_ctrl;
  assign o_alu_result = r_alu_result;
  assign o_mem_rdata  = r_mem_rdata;
  assign o_rd         = r_rd;
endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB register, register-file write port, WB->EX forwarding tap
// and saturating retired-instruction counter.
module mem_wb_writeback
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [REG_AW-1:0] in_rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count
);
  logic              w_valid;
  wb_ctrl_t          w_ctrl;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [REG_AW-1:0] w_rd;
  logic              w_we;
  logic              w_adv;
  logic [CNT_W-1:0]  r_cnt;
  mem_wb_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_valid      (in_valid),
    .i_ctrl       ('{memtoreg: in_memtoreg, regwrite: in_regwrite}),
    .i_alu_result (in_alu_result),
    .i_mem_rdata  (in_mem_rdata),
    .i_rd         (in_rd),
    .o_valid      (w_valid),
    .o_ctrl       (w_ctrl),
    .o_alu_result (w_alu_result),
    .o_mem_rdata  (w_mem_rdata),
    .o_rd         (w_rd)
  );
  // Register 0 is hardwired zero, so writes to it are dropped here.
  assign w_we      = w_valid & w_ctrl.regwrite & (w_rd != REG_AW'(REG_ZERO));
  assign rf_we     = w_we;
  assign rf_waddr  = w_we ? w_rd : '0;
  assign rf_wdata  = !w_we ? '0 : w_ctrl.memtoreg ? w_mem_rdata : w_alu_result;
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
  // A flushed instruction still leaves WB, so it retires even under stall.
  assign w_adv = w_valid & (~stall | flush);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_adv && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign retired_count = r_cnt;
endmodule
